// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared widths and host FSM encoding for the quadrature peripheral
package quad_pkg;

  localparam int COUNT_W    = 16;  // position count width
  localparam int SPEED_W    = 8;   // per-interval speed count width
  localparam int SEQ_W      = 8;   // published-sample sequence width
  localparam int INTERVAL_W = 8;   // base ticks per speed interval

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCK    = 2'd1,
    ST_RELEASE = 2'd2
  } host_state_t;

endpackage

// File: rtl/interval_tick_gen.sv
// rtl/interval_tick_gen.sv - prescaler, interval counter and speed interval pulse register
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   interval_ticks        base ticks per interval; 0 stops the pulse
//   speed_interval_pulse  registered one-cycle strobe at the end of each interval
module interval_tick_gen
  import quad_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INTERVAL_W-1:0] interval_ticks,
  output logic                  speed_interval_pulse
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]         presc_cnt;
  logic                  tick;
  logic [INTERVAL_W-1:0] ival_cnt;
  logic [INTERVAL_W:0]   ival_next;

  assign tick      = (presc_cnt == PW'(PRESCALE - 1));
  // One bit wider so the compare cannot wrap.
  assign ival_next = {1'b0, ival_cnt} + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // ">=" rather than "==" so lowering interval_ticks below the running
  // count fires on the next tick instead of waiting for a full wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ival_cnt             <= '0;
      speed_interval_pulse <= 1'b0;
    end else begin
      speed_interval_pulse <= 1'b0;
      if (interval_ticks == '0) begin
        ival_cnt <= '0;
      end else if (tick) begin
        if (ival_next >= {1'b0, interval_ticks}) begin
          ival_cnt             <= '0;
          speed_interval_pulse <= 1'b1;
        end else begin
          ival_cnt <= ival_next[INTERVAL_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/quad_sample_sched.sv
// rtl/quad_sample_sched.sv - interval scheduler and coherent snapshot controller for two pulse counters
//
// Ports:
//   clk, reset                           clock, asynchronous active-high reset
//   interval_ticks                       base ticks per speed interval (0 = off)
//   speed_interval_pulse                 strobe to both counters
//   counter_en                           en of both counters, low while a snapshot is held
//   left_count, right_count              live position counts
//   left_speed, right_speed              speed counts from the counters
//   rd_req / rd_ack                      host snapshot request level / snapshot stable
//   snap_left_count, snap_right_count    frozen position counts
//   snap_left_speed, snap_right_speed    latest published speed samples
//   snap_seq                             published-sample sequence number
//   intr                                 one-cycle pulse per published sample
module quad_sample_sched
  import quad_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int FWD      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INTERVAL_W-1:0] interval_ticks,
  output logic                  speed_interval_pulse,
  output logic                  counter_en,
  input  logic [COUNT_W-1:0]    left_count,
  input  logic [COUNT_W-1:0]    right_count,
  input  logic [SPEED_W-1:0]    left_speed,
  input  logic [SPEED_W-1:0]    right_speed,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic [COUNT_W-1:0]    snap_left_count,
  output logic [COUNT_W-1:0]    snap_right_count,
  output logic [SPEED_W-1:0]    snap_left_speed,
  output logic [SPEED_W-1:0]    snap_right_speed,
  output logic [SEQ_W-1:0]      snap_seq,
  output logic                  intr
);

  // FWD only matters to the counters; it is referenced here so it stays part
  // of this block's parameter set when the pair is wired up together.
  if (FWD != 0) begin : g_fwd_passthru
  end

  host_state_t state, state_next;

  logic en_d, ack_d, latch_counts, pub_ok;
  logic pulse_d;
  logic pend_valid;
  logic [SPEED_W-1:0] pend_left, pend_right;

  interval_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk                  (clk),
    .reset                (reset),
    .interval_ticks       (interval_ticks),
    .speed_interval_pulse (speed_interval_pulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (rd_req)  state_next = ST_LOCK;
      ST_LOCK:    if (!rd_req) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so rd_ack and
  // counter_en change on the same edge as the state. Publishing is keyed to
  // the next state too: the edge that leaves LOCK already publishes, so a
  // sample held back by a snapshot appears during the RELEASE cycle.
  always_comb begin
    en_d         = (state_next == ST_IDLE);
    ack_d        = (state_next == ST_LOCK);
    latch_counts = (state == ST_IDLE) && rd_req;
    pub_ok       = (state_next != ST_LOCK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_en       <= 1'b1;
      rd_ack           <= 1'b0;
      snap_left_count  <= '0;
      snap_right_count <= '0;
    end else begin
      counter_en <= en_d;
      rd_ack     <= ack_d;
      if (latch_counts) begin
        snap_left_count  <= left_count;
        snap_right_count <= right_count;
      end
    end
  end

  // Counters load speed_count at the end of the pulse cycle, so the sample is
  // taken one cycle later (pulse_d). When publishing is allowed the fresh
  // sample bypasses spd_pend; otherwise it waits there, and a newer capture
  // simply overwrites it so only one publish results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_d          <= 1'b0;
      pend_valid       <= 1'b0;
      pend_left        <= '0;
      pend_right       <= '0;
      snap_left_speed  <= '0;
      snap_right_speed <= '0;
      snap_seq         <= '0;
      intr             <= 1'b0;
    end else begin
      pulse_d <= speed_interval_pulse;
      intr    <= 1'b0;
      if (pulse_d) begin
        pend_left  <= left_speed;
        pend_right <= right_speed;
      end
      if (pub_ok && (pulse_d || pend_valid)) begin
        snap_left_speed  <= pulse_d ? left_speed  : pend_left;
        snap_right_speed <= pulse_d ? right_speed : pend_right;
        snap_seq         <= snap_seq + SEQ_W'(1);
        intr             <= 1'b1;
        pend_valid       <= 1'b0;
      end else if (pulse_d) begin
        pend_valid <= 1'b1;
      end
    end
  end

endmodule
